// File: rtl/conv_window_reader.sv
// Read-side controller for the three kernel-row FIFOs: issues lock-step reads, assembles
// the 3x3 window into a 2-entry output buffer and sequences one feature-map pass per start.
module conv_window_reader #(
   parameter int  DATA_WIDTH      = 32,
   parameter int  INPUT_COL_WIDTH = 6,
   parameter int  FIFO_DEPTH      = 32,
   parameter int  KERNEL_SIZE     = 3,
   localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic                             i_start,
   input  logic [INPUT_COL_WIDTH-1:0]       i_output_size,
   input  logic [INPUT_COL_WIDTH-1:0]       i_output_rows,
   input  logic [2:0][CW-1:0]               i_fifo_count,
   input  logic [2:0][2:0][DATA_WIDTH-1:0]  i_fifo_rdata,
   input  logic [2:0]                       i_fifo_rvalid,
   output logic [2:0]                       o_fifo_renable,
   output logic [INPUT_COL_WIDTH-1:0]       o_valid_read_count,
   output logic [8:0][DATA_WIDTH-1:0]       o_window,
   output logic                             o_window_valid,
   input  logic                             i_window_ready,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_error
);

   generate
      if (KERNEL_SIZE != 3) begin : g_kernel_size_check
         $error("conv_window_reader supports KERNEL_SIZE == 3 only");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic [8:0][DATA_WIDTH-1:0] window_t;

   localparam logic [INPUT_COL_WIDTH-1:0] ZERO_C      = {INPUT_COL_WIDTH{1'b0}};
   localparam logic [INPUT_COL_WIDTH-1:0] ONE_C       = {{(INPUT_COL_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INPUT_COL_WIDTH-1:0] TWO_C       = {{(INPUT_COL_WIDTH-2){1'b0}}, 2'b10};
   localparam logic [CW-1:0]              MIN_COUNT_C = {{(CW-2){1'b0}}, 2'b11};
   localparam window_t                    WIN_ZERO_C  = {(9*DATA_WIDTH){1'b0}};

   state_t                       state_r, state_nxt_s;
   logic [INPUT_COL_WIDTH-1:0]   size_r, rows_r, col_r, row_r, rc_hold_r, col_m1_s;
   logic                         inflight_r, busy_r, done_r, error_r;
   window_t                      buf0_r, buf1_r, rdata_win_s;
   logic [1:0]                   buf_cnt_r;
   logic                         start_ok_s, start_bad_s, sizes_ok_s, counts_ok_s, room_s;
   logic                         issue_s, last_col_s, last_row_s, pop_s, push_s;
   logic                         rvalid_bad_s, drain_exit_s;

   // Read-issue, buffer-handshake and pass-position decode.
   always_comb begin
      sizes_ok_s  = (i_output_size >= TWO_C) && (i_output_rows != ZERO_C);
      start_ok_s  = (state_r == ST_IDLE) && i_start && sizes_ok_s;
      start_bad_s = (state_r == ST_IDLE) && i_start && !sizes_ok_s;
      counts_ok_s = 1'b1;
      for (int r = 0; r < 3; r++) begin
         counts_ok_s = counts_ok_s && (i_fifo_count[r] >= MIN_COUNT_C);
      end
      pop_s  = (buf_cnt_r != 2'd0) && i_window_ready;
      push_s = inflight_r;
      // A slot freed by this cycle's pop counts as room, which keeps reads back-to-back.
      room_s = ({1'b0, buf_cnt_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
      issue_s      = (state_r == ST_RUN) && counts_ok_s && room_s;
      last_col_s   = (col_r == (size_r - ONE_C));
      last_row_s   = (row_r == (rows_r - ONE_C));
      col_m1_s     = col_r - ONE_C;
      rvalid_bad_s = inflight_r && (i_fifo_rvalid != 3'b111);
      drain_exit_s = !inflight_r && ((buf_cnt_r == 2'd0) || ((buf_cnt_r == 2'd1) && pop_s));
      // Packed layout already places FIFO r port c at window index r*3+c.
      rdata_win_s  = i_fifo_rdata;
   end

   // Next-state logic for the pass sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_nxt_s = ST_RUN;
            end else if (start_bad_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (issue_s && last_col_s && last_row_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_exit_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, pass counters, column-code hold and status flags.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r    <= ST_IDLE;
         size_r     <= ZERO_C;
         rows_r     <= ZERO_C;
         col_r      <= ZERO_C;
         row_r      <= ZERO_C;
         rc_hold_r  <= ZERO_C;
         inflight_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         inflight_r <= issue_s;
         busy_r     <= (state_nxt_s != ST_IDLE);
         done_r     <= (state_nxt_s == ST_DONE);
         if (start_ok_s) begin
            size_r <= i_output_size;
            rows_r <= i_output_rows;
            col_r  <= ZERO_C;
            row_r  <= ZERO_C;
         end else if (issue_s) begin
            if (last_col_s) begin
               col_r <= ZERO_C;
               row_r <= row_r + ONE_C;
            end else begin
               col_r <= col_r + ONE_C;
            end
         end
         if (issue_s) begin
            rc_hold_r <= col_m1_s;
         end
         if (start_ok_s) begin
            error_r <= 1'b0;
         end else if (start_bad_s || rvalid_bad_s) begin
            error_r <= 1'b1;
         end
      end
   end

   // Two-entry output buffer; entry 0 is always the head shown on o_window.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         buf_cnt_r <= 2'd0;
         buf0_r    <= WIN_ZERO_C;
         buf1_r    <= WIN_ZERO_C;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (buf_cnt_r == 2'd0) begin
                  buf0_r <= rdata_win_s;
               end else begin
                  buf1_r <= rdata_win_s;
               end
               buf_cnt_r <= buf_cnt_r + 2'd1;
            end
            2'b01: begin
               buf0_r    <= buf1_r;
               buf_cnt_r <= buf_cnt_r - 2'd1;
            end
            2'b11: begin
               if (buf_cnt_r == 2'd1) begin
                  buf0_r <= rdata_win_s;
               end else begin
                  buf0_r <= buf1_r;
                  buf1_r <= rdata_win_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_fifo_renable     = {3{issue_s}};
   assign o_valid_read_count = issue_s ? col_m1_s : rc_hold_r;
   assign o_window           = buf0_r;
   assign o_window_valid     = (buf_cnt_r != 2'd0);
   assign o_busy             = busy_r;
   assign o_done             = done_r;
   assign o_error            = error_r;

endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader: FIFO responder model with random data,
// in-order window scoreboard, column-code model and per-scenario pass checks.
module tb_conv_window_reader;
   localparam int DW  = 32;
   localparam int ICW = 6;
   localparam int CW  = 6;

   typedef logic [8:0][DW-1:0] win_t;

   logic                      clk = 1'b0;
   logic                      rst, start, wready, wvalid, busy, done, err;
   logic [ICW-1:0]            osize, orows, code;
   logic [2:0][CW-1:0]        fcount;
   logic [2:0][2:0][DW-1:0]   frdata;
   logic [2:0]                frvalid, ren;
   win_t                      win;

   always #5 clk = ~clk;

   conv_window_reader #(.DATA_WIDTH(DW), .INPUT_COL_WIDTH(ICW), .FIFO_DEPTH(32), .KERNEL_SIZE(3)) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_output_size(osize), .i_output_rows(orows),
      .i_fifo_count(fcount), .i_fifo_rdata(frdata), .i_fifo_rvalid(frvalid),
      .o_fifo_renable(ren), .o_valid_read_count(code), .o_window(win), .o_window_valid(wvalid),
      .i_window_ready(wready), .o_busy(busy), .o_done(done), .o_error(err));

   // knobs
   bit             rst_v, start_pend, ready_v, rnd_mode, err_allowed;
   logic [ICW-1:0] size_v, rows_v;
   logic [CW-1:0]  cnt_v [3];
   int             bad_resp_idx;
   // model / bookkeeping
   win_t exp_q[$];
   win_t held;
   bit   pending, held_valid;
   int   read_n, resp_n, size_m, total_m, cyc;
   int   ren_cnt, first_ren, last_ren, acc_cnt, last_acc, done_cnt, done_cyc;
   int   n_checks, n_errors;

   task automatic clear_model();
      exp_q.delete();
      pending = 1'b0; held_valid = 1'b0;
      read_n = 0; resp_n = 0; ren_cnt = 0; first_ren = -1; last_ren = -1;
      acc_cnt = 0; last_acc = -1; done_cnt = 0; done_cyc = -1;
   endtask

   task automatic cycle();
      bit   resp_now, low;
      int   pop, col;
      win_t w;
      logic [ICW-1:0] ec;
      @(negedge clk);
      cyc++;
      resp_now = pending;
      pending  = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            frdata[r][c] = $urandom();
      frvalid = 3'b000;
      if (resp_now && !rst_v) begin
         resp_n++;
         frvalid = (resp_n == bad_resp_idx) ? 3'b101 : 3'b111;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               w[r*3+c] = frdata[r][c];
         exp_q.push_back(w);
      end
      if (rnd_mode) begin
         wready = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < 3; r++) fcount[r] = ($urandom_range(0, 4) == 0) ? 6'd2 : 6'd32;
      end else begin
         wready = ready_v;
         for (int r = 0; r < 3; r++) fcount[r] = cnt_v[r];
      end
      rst = rst_v; start = start_pend; start_pend = 1'b0;
      osize = size_v; orows = rows_v;
      #1;
      if (!rst_v) begin
         n_checks++;
         if (ren !== 3'b000 && ren !== 3'b111) begin
            n_errors++; $display("FAIL renable_sync: got %b required all-equal", ren);
         end
         pop = (wvalid === 1'b1 && wready) ? 1 : 0;
         if (ren === 3'b111) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc;
            last_ren = cyc;
            col = read_n % size_m;
            ec  = (col == 0) ? 6'h3F : 6'(col - 1);
            n_checks++;
            if (code !== ec) begin
               n_errors++; $display("FAIL read_code: read %0d got %0h required %0h", read_n, code, ec);
            end
            low = 1'b0;
            for (int r = 0; r < 3; r++) if (fcount[r] < 6'd3) low = 1'b1;
            n_checks++;
            if (low) begin
               n_errors++; $display("FAIL read_when_low: got renable=1 required 0 (counts %0d %0d %0d)",
                                    fcount[0], fcount[1], fcount[2]);
            end
            n_checks++;
            if (exp_q.size() - pop >= 2) begin
               n_errors++; $display("FAIL read_overrun: got occupancy %0d required < 2", exp_q.size() - pop);
            end
            n_checks++;
            if (read_n >= total_m) begin
               n_errors++; $display("FAIL extra_read: got read %0d required < %0d", read_n + 1, total_m);
            end
            read_n++;
            pending = 1'b1;
         end
         if (held_valid) begin
            n_checks++;
            if (wvalid !== 1'b1 || win !== held) begin
               n_errors++; $display("FAIL window_hold: got valid=%b win0=%0h required 1 / %0h", wvalid, win[0], held[0]);
            end
         end
         held_valid = (wvalid === 1'b1) && !wready;
         held = win;
         if (wvalid === 1'b1) begin
            n_checks++;
            if (exp_q.size() - int'(resp_now) <= 0) begin
               n_errors++; $display("FAIL spurious_window: got valid=1 required 0");
            end else if (wready) begin
               w = exp_q.pop_front();
               if (win !== w) begin
                  n_errors++; $display("FAIL window_data: window %0d got %0h.. required %0h..", acc_cnt, win[0], w[0]);
               end
               acc_cnt++;
               last_acc = cyc;
            end
         end
         if (done === 1'b1) begin
            done_cnt++; done_cyc = cyc;
         end
         if (!err_allowed) begin
            n_checks++;
            if (err !== 1'b0) begin
               n_errors++; $display("FAIL spurious_error: got %b required 0", err);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_v = 1'b1;
      cycle();
      cycle();
      rst_v = 1'b0;
      clear_model();
   endtask

   task automatic begin_pass(input int sz, input int rw);
      clear_model();
      size_v = 6'(sz); rows_v = 6'(rw);
      size_m = sz; total_m = sz * rw;
      start_pend = 1'b1;
      cycle();
   endtask

   task automatic run_to_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (done_cnt != 0) break;
      end
      n_checks++;
      if (done_cnt == 0) begin
         n_errors++; $display("FAIL done_timeout: got no o_done within %0d cycles", budget);
      end
   endtask

   task automatic finish_pass_checks(input string name);
      cycle();
      n_checks++;
      if (acc_cnt != total_m) begin
         n_errors++; $display("FAIL %s_windows: got %0d required %0d", name, acc_cnt, total_m);
      end
      n_checks++;
      if (done_cnt != 1 || done_cyc != last_acc + 1) begin
         n_errors++; $display("FAIL %s_done: got %0d pulses at %0d required 1 at %0d", name, done_cnt, done_cyc, last_acc + 1);
      end
      n_checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_errors++; $display("FAIL %s_idle: got left=%0d busy=%b required 0/0", name, exp_q.size(), busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      cycle();
      n_checks++; if (ren !== 3'b000) begin n_errors++; $display("FAIL reset_renable: got %b required 000", ren); end
      n_checks++; if (code !== 6'h00) begin n_errors++; $display("FAIL reset_code: got %0h required 0", code); end
      n_checks++; if (win !== {(9*DW){1'b0}}) begin n_errors++; $display("FAIL reset_window: got %0h required 0", win[0]); end
      n_checks++; if (wvalid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b required 0", wvalid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b required 0", done); end
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b required 0", err); end
   endtask

   task automatic test_back_to_back();
      int st;
      begin_pass(4, 2);
      st = cyc;
      cycle();
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy: got %b required 1", busy); end
      run_to_done(60);
      n_checks++;
      if (ren_cnt != 8 || first_ren != st + 1 || last_ren - first_ren != 7) begin
         n_errors++; $display("FAIL b2b_renable: got %0d reads over cycles %0d..%0d required 8 over %0d..%0d",
                              ren_cnt, first_ren, last_ren, st + 1, st + 8);
      end
      finish_pass_checks("b2b");
   endtask

   task automatic test_backpressure();
      int r0;
      begin_pass($urandom_range(4, 7), $urandom_range(2, 3));
      for (int i = 0; i < 30 && acc_cnt < 2; i++) cycle();
      ready_v = 1'b0;
      cycle(); cycle();
      r0 = ren_cnt;
      cycle(); cycle(); cycle();
      n_checks++;
      if (ren_cnt != r0 || exp_q.size() != 2 || wvalid !== 1'b1) begin
         n_errors++; $display("FAIL bp_stall: got reads +%0d buffered %0d required +0 / 2", ren_cnt - r0, exp_q.size());
      end
      ready_v = 1'b1;
      run_to_done(80);
      finish_pass_checks("bp");
   endtask

   task automatic test_count_stall();
      int r0;
      begin_pass(3, 3);
      cycle(); cycle(); cycle();
      cnt_v[1] = 6'd2;
      cycle();
      r0 = ren_cnt;
      for (int i = 0; i < 5; i++) cycle();
      n_checks++;
      if (ren_cnt != r0) begin n_errors++; $display("FAIL stall_reads: got +%0d reads required +0", ren_cnt - r0); end
      cnt_v[1] = 6'd3;
      cycle();
      n_checks++;
      if (ren_cnt != r0 + 1) begin n_errors++; $display("FAIL stall_resume: got +%0d reads required +1", ren_cnt - r0); end
      cnt_v[1] = 6'd32;
      run_to_done(60);
      finish_pass_checks("stall");
   endtask

   task automatic test_start_ignored();
      begin_pass(3, 2);
      cycle(); cycle();
      size_v = 6'd2; rows_v = 6'd1;
      start_pend = 1'b1;
      cycle();
      run_to_done(60);
      finish_pass_checks("ign");
   endtask

   task automatic test_rvalid_error();
      err_allowed = 1'b1;
      bad_resp_idx = 3;
      begin_pass(4, 1);
      for (int i = 0; i < 20 && resp_n < 3; i++) cycle();
      n_checks++;
      if (err !== 1'b0) begin n_errors++; $display("FAIL rv_error_early: got %b required 0", err); end
      cycle();
      n_checks++;
      if (err !== 1'b1) begin n_errors++; $display("FAIL rv_error_set: got %b required 1", err); end
      run_to_done(40);
      finish_pass_checks("rv");
      n_checks++;
      if (err !== 1'b1) begin n_errors++; $display("FAIL rv_error_sticky: got %b required 1", err); end
      bad_resp_idx = -1;
   endtask

   task automatic test_bad_size();
      err_allowed = 1'b1;
      begin_pass(1, 2);
      cycle();
      n_checks++;
      if (done !== 1'b1 || err !== 1'b1 || ren_cnt != 0) begin
         n_errors++; $display("FAIL bad_size: got done=%b err=%b reads=%0d required 1/1/0", done, err, ren_cnt);
      end
      cycle();
      n_checks++;
      if (done !== 1'b0 || err !== 1'b1) begin
         n_errors++; $display("FAIL bad_size_after: got done=%b err=%b required 0/1", done, err);
      end
      begin_pass(2, 1);
      cycle();
      n_checks++;
      if (err !== 1'b0) begin n_errors++; $display("FAIL error_clear: got %b required 0", err); end
      err_allowed = 1'b0;
      run_to_done(30);
      finish_pass_checks("clr");
   endtask

   task automatic test_reset_mid();
      begin_pass(6, 2);
      ready_v = 1'b0;
      for (int i = 0; i < 10 && wvalid !== 1'b1; i++) cycle();
      size_v = 6'd2; rows_v = 6'd1;
      start_pend = 1'b1;
      cycle();
      rst_v = 1'b1;
      cycle();
      rst_v = 1'b0;
      clear_model();
      cycle();
      n_checks++;
      if (ren !== 3'b000 || wvalid !== 1'b0 || win !== {(9*DW){1'b0}} || busy !== 1'b0 ||
          done !== 1'b0 || code !== 6'h00 || err !== 1'b0) begin
         n_errors++; $display("FAIL midreset_outputs: got ren=%b v=%b busy=%b done=%b code=%0h err=%b required all 0",
                              ren, wvalid, busy, done, code, err);
      end
      ready_v = 1'b1;
      begin_pass(2, 2);
      run_to_done(40);
      finish_pass_checks("recover");
   endtask

   task automatic test_random();
      rnd_mode = 1'b1;
      for (int p = 0; p < 3; p++) begin
         begin_pass($urandom_range(2, 7), $urandom_range(1, 3));
         run_to_done(400);
         finish_pass_checks("rnd");
      end
      rnd_mode = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; cyc = 0;
      rst = 1'b1; start = 1'b0; wready = 1'b1; osize = 6'd0; orows = 6'd0;
      fcount = {3{6'd32}}; frdata = {(9*DW){1'b0}}; frvalid = 3'b000;
      rst_v = 1'b0; start_pend = 1'b0; ready_v = 1'b1; rnd_mode = 1'b0; err_allowed = 1'b0;
      size_v = 6'd0; rows_v = 6'd0; bad_resp_idx = -1; size_m = 1; total_m = 0;
      for (int r = 0; r < 3; r++) cnt_v[r] = 6'd32;
      clear_model();
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_count_stall();
      test_start_ignored();
      test_rvalid_error();
      test_bad_size();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
